// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: act codes, opcodes and control FSM states.
package alu_pkg;

   typedef enum logic [1:0] {
      ActIdle,
      ActLoadA,
      ActLoadB,
      ActExecute
   } act_e;

   typedef enum logic [3:0] {
      OpNot,
      OpAnd,
      OpOr,
      OpShl,
      OpShr,
      OpEq,
      OpNe,
      OpLt,
      OpGt,
      OpLe,
      OpGe,
      OpAdd,
      OpSub,
      OpSra,
      OpMul,
      OpXor
   } opcode_e;

   typedef enum logic [0:0] {
      StIdle,
      StMultiply
   } state_e;

endpackage

// File: rtl/alu_multiplier_iterative.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a product.
// One partial-product step per cycle over WIDTH cycles.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset (aborts)
//   start_i          snapshot operands and begin; only asserted while idle
//   multiplicand_i   operand A
//   multiplier_i     operand B
//   busy_o           steps remain
//   done_o           the step taken on the coming edge is the last one
//   product_o        accumulator after the coming step; final when done_o is high
module alu_multiplier_iterative #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] multiplicand_i,
   input  logic [WIDTH-1:0] multiplier_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int unsigned CntWidth = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0]    mplier_q, mplier_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic [WIDTH-1:0]    step_acc;

   // Multiplicand shifts left; bits beyond WIDTH never affect the low product.
   assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      if (start_i) begin
         mcand_d  = multiplicand_i;
         mplier_d = multiplier_i;
         acc_d    = '0;
         count_d  = CntWidth'(WIDTH);
      end else if (count_q != '0) begin
         acc_d    = step_acc;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q - CntWidth'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

   assign busy_o    = (count_q != '0);
   assign done_o    = (count_q == CntWidth'(1));
   assign product_o = step_acc;

endmodule

// File: rtl/arithmetic_logic_unit_pipelined.sv
// WIDTH-bit ALU with act-coded load/execute protocol, single-cycle logic/arith
// ops and an iterative multiplier, plus zero/carry flags and a sticky error.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   act            0 idle, 1 load A, 2 load B, 3 execute (ignored while busy)
//   data           operand for loads; opcode in data[3:0] for execute
//   result         registered result of the last completed operation
//   result_valid   one-cycle pulse when result/flags update
//   busy           multiply in flight
//   flag_zero      result == 0
//   flag_carry     ADD carry-out / SUB borrow, else 0
//   error          sticky unsupported-opcode indication
module arithmetic_logic_unit_pipelined
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SHAMT_WIDTH = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       act,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             error
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] operand_a_q, operand_a_d;
   logic [WIDTH-1:0] operand_b_q, operand_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             error_q, error_d;

   opcode_e          op;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic             shamt_big;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_legal;

   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign op        = opcode_e'(data[3:0]);
   assign shamt     = operand_b_q[SHAMT_WIDTH-1:0];
   assign shamt_big = (shamt >= SHAMT_WIDTH'(WIDTH));
   assign sum       = {1'b0, operand_a_q} + {1'b0, operand_b_q};

   // Single-cycle datapath.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_legal = 1'b1;
      unique case (op)
         OpNot: alu_res = ~operand_a_q;
         OpAnd: alu_res = operand_a_q & operand_b_q;
         OpOr:  alu_res = operand_a_q | operand_b_q;
         OpXor: alu_res = operand_a_q ^ operand_b_q;
         OpShl: alu_res = shamt_big ? '0 : (operand_a_q << shamt);
         OpShr: alu_res = shamt_big ? '0 : (operand_a_q >> shamt);
         OpSra: alu_res = shamt_big ? {WIDTH{operand_a_q[WIDTH-1]}}
                                    : WIDTH'($signed(operand_a_q) >>> shamt);
         OpEq:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q == operand_b_q};
         OpNe:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q != operand_b_q};
         OpLt:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q <  operand_b_q};
         OpGt:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q >  operand_b_q};
         OpLe:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q <= operand_b_q};
         OpGe:  alu_res = {{(WIDTH-1){1'b0}}, operand_a_q >= operand_b_q};
         OpAdd: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         OpSub: begin
            alu_res   = operand_a_q - operand_b_q;
            alu_carry = (operand_a_q < operand_b_q);
         end
         OpMul: alu_res = '0;  // multi-cycle, handled by the FSM
         // Reached only if the opcode space is extended beyond what is decoded here.
         default: alu_legal = 1'b0;
      endcase
   end

   // Control FSM and architectural state next values.
   always_comb begin
      state_d     = state_q;
      operand_a_d = operand_a_q;
      operand_b_d = operand_b_q;
      result_d    = result_q;
      valid_d     = 1'b0;
      zero_d      = zero_q;
      carry_d     = carry_q;
      error_d     = error_q;
      mul_start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            unique case (act_e'(act))
               ActLoadA: operand_a_d = data;
               ActLoadB: operand_b_d = data;
               ActExecute: begin
                  if (op == OpMul) begin
                     mul_start = 1'b1;
                     state_d   = StMultiply;
                  end else if (alu_legal) begin
                     result_d = alu_res;
                     zero_d   = (alu_res == '0);
                     carry_d  = alu_carry;
                     valid_d  = 1'b1;
                  end else begin
                     error_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         StMultiply: begin
            if (mul_done) begin
               result_d = mul_product;
               zero_d   = (mul_product == '0);
               carry_d  = 1'b0;
               valid_d  = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         operand_a_q <= '0;
         operand_b_q <= '0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         operand_a_q <= operand_a_d;
         operand_b_q <= operand_b_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         error_q     <= error_d;
      end
   end

   alu_multiplier_iterative #(
      .WIDTH(WIDTH)
   ) u_multiplier (
      .clock          (clock),
      .reset          (reset),
      .start_i        (mul_start),
      .multiplicand_i (operand_a_q),
      .multiplier_i   (operand_b_q),
      .busy_o         (mul_busy),
      .done_o         (mul_done),
      .product_o      (mul_product)
   );

   assign result       = result_q;
   assign result_valid = valid_q;
   assign busy         = mul_busy;
   assign flag_zero    = zero_q;
   assign flag_carry   = carry_q;
   assign error        = error_q;

endmodule
